result_bcd_converter: RTL

Sequential binary-to-BCD converter that sits directly downstream of the calculator's combinational 4x4 multiplier and other arithmetic units. It captures an unsigned WIDTH-bit result, such as the 8-bit product, on a start strobe. It runs an iterative shift-and-add-3 (double-dabble) conversion and presents DIGITS packed BCD digits, with a one-cycle done pulse, for the display driver.

---
 rtl/calc_pkg.sv | 13 +
 rtl/bcd_add3_digit.sv | 11 +
 rtl/result_bcd_converter.sv | 99 +++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath constants and the BCD converter state encoding.
package calc_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned CALC_WIDTH  = 8;
  localparam int unsigned CALC_DIGITS = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = CALC_WIDTH,
  parameter int unsigned DIGITS = CALC_DIGITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   corr_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Per-digit correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (corr_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        scratch_d = {corr_c[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        // Last bit shifted in: publish the whole result at once.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
